// File: rtl/recovery_rom_fetcher.sv
// Recovery ROM fetch initiator. On start it streams the recovery routine out of
// the code ROM (one-cycle registered-address read), buffers words in a small
// first-word-fall-through FIFO and hands them to the core over valid/ready.
// Fetching ends at the first dret opcode or after MAX_WORDS words.
module recovery_rom_fetcher #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_WORDS   = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] STOP_OPCODE = 32'h7b20_0073
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WORDS);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;          // words requested so far
    logic             pending_q, pending_d;  // a ROM response arrives this cycle
    logic [31:0]      req_addr_q, req_addr_d; // address of the in-flight request
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [31:0] data_mem_q [FIFO_DEPTH];
    logic [31:0] addr_mem_q [FIFO_DEPTH];

    logic             fifo_empty;
    logic [OCC_W-1:0] fill;
    logic             stop_hit;
    logic             issue;
    logic             push;
    logic             pop;

    // Issue decision and the combinational output view of the block.
    always_comb begin
        fifo_empty = (occ_q == '0);
        // Slots already promised: stored words plus the response still in flight.
        fill       = occ_q + OCC_W'(pending_q);
        stop_hit   = pending_q && (rom_rdata_i == STOP_OPCODE);
        // Holding off the request while dret is being captured means no
        // response past dret is ever fetched, so there is nothing to discard.
        issue      = (state_q == ST_FETCH) && (fill < OCC_FULL) &&
                     (cnt_q < CNT_MAX) && !stop_hit;
        push       = pending_q;
        pop        = !fifo_empty && instr_ready_i;

        rom_req_o     = issue;
        rom_addr_o    = BASE_ADDR + (32'(cnt_q) << 2);
        instr_valid_o = !fifo_empty;
        instr_rdata_o = data_mem_q[rd_ptr_q];
        instr_addr_o  = addr_mem_q[rd_ptr_q];
        busy_o        = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        done_o        = (state_q == ST_DRAIN) && fifo_empty && !flush_i;
    end

    // Sequencing FSM, request bookkeeping and FIFO pointer/occupancy update.
    always_comb begin
        // NOTE: every variable starts from its held value so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;

        if (flush_i) begin
            // Abort wins over everything, including a simultaneous start.
            state_d   = ST_IDLE;
            pending_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                    end
                end
                ST_FETCH: begin
                    pending_d = issue;
                    if (issue) begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        req_addr_d = rom_addr_o;
                    end
                    if (stop_hit) begin
                        state_d = ST_DRAIN;
                    end else if ((cnt_d == CNT_MAX) && !pending_d) begin
                        // Limit reached and its last response captured this cycle.
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            req_addr_q <= BASE_ADDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // FIFO storage write: captured word together with the address it came from.
    // NOTE: storage is not reset; occupancy qualifies every entry so stale contents never show.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            data_mem_q[wr_ptr_q] <= rom_rdata_i;
            addr_mem_q[wr_ptr_q] <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_recovery_rom_fetcher.sv
// Self-checking bench for recovery_rom_fetcher: a ROM model, a word-list
// reference model built from the ROM contents, and a negedge monitor.
module tb_recovery_rom_fetcher;

    localparam int          MAXW  = 8;
    localparam int          DEPTH = 4;
    localparam int          AW    = $clog2(MAXW);
    localparam logic [31:0] STOP  = 32'h7b20_0073;

    logic        clk_i         = 1'b0;
    logic        rst_i         = 1'b1;
    logic        start_i       = 1'b0;
    logic        flush_i       = 1'b0;
    logic        instr_ready_i = 1'b0;
    logic [31:0] rom_rdata_i   = '0;
    logic        rom_req_o, instr_valid_o, busy_o, done_o;
    logic [31:0] rom_addr_o, instr_rdata_o, instr_addr_o;

    logic [31:0] rom [MAXW];

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q [$];          // {addr, data} words the consumer must see
    int          exp_reqs     = 0;
    int          req_seen     = 0;
    int          pop_seen     = 0;
    int          done_seen    = 0;
    int          cyc          = 0;
    int          last_pop_cyc = 0;
    bit          mon_en       = 1'b0;
    bit          in_seq       = 1'b0;

    always #5 clk_i = ~clk_i;

    recovery_rom_fetcher #(
        .BASE_ADDR  (32'h0000_0000),
        .MAX_WORDS  (MAXW),
        .FIFO_DEPTH (DEPTH),
        .STOP_OPCODE(STOP)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .flush_i      (flush_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_rdata_i  (rom_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_rdata_o(instr_rdata_o),
        .instr_addr_o (instr_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // ROM with registered address: data shows up the cycle after the request.
    always @(posedge clk_i) begin
        if (rom_req_o) begin
            rom_rdata_i <= (rom_addr_o < 32'(MAXW * 4)) ? rom[rom_addr_o[AW+1:2]] : 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Reference: the consumer sees ROM words from address 0 up to and
    // including the first dret, or the first MAXW words if there is none.
    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < MAXW; i++) begin
            exp_q.push_back({32'(i * 4), rom[i]});
            if (rom[i] == STOP) break;
        end
        exp_reqs = exp_q.size();
    endtask

    task automatic load_basic();
        rom[0] = 32'h02a1_0113;
        rom[1] = 32'h0161_0113;
        rom[2] = 32'h00b1_0113;
        rom[3] = 32'h7b20_0073;
        for (int i = 4; i < MAXW; i++) rom[i] = 32'h0000_0013;
    endtask

    // Monitor: request order and window, delivered words, busy and done timing.
    always @(negedge clk_i) begin
        logic [63:0] e;
        cyc++;
        if (mon_en) begin
            check("busy", 32'(busy_o), 32'(in_seq));
            if (rom_req_o) begin
                check("req_addr", rom_addr_o, 32'(req_seen * 4));
                check("req_window", 32'((req_seen - pop_seen) < DEPTH), 32'd1);
                req_seen++;
            end
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_model", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_addr", instr_addr_o, e[63:32]);
                    check("instr_data", instr_rdata_o, e[31:0]);
                end
                pop_seen++;
                last_pop_cyc = cyc;
            end
            if (done_o) begin
                check("done_in_seq", 32'(in_seq), 32'd1);
                check("done_model_empty", 32'(exp_q.size()), 32'd0);
                check("done_timing", 32'(cyc), 32'(last_pop_cyc + 1));
                done_seen++;
                in_seq = 1'b0;
            end
        end
    end

    // One full fetch sequence: random ready, optional initial hold-off,
    // optional start pulse while busy.
    task automatic run_seq(input int ready_pct, input int hold, input bit restart);
        build_expected();
        req_seen  = 0;
        pop_seen  = 0;
        done_seen = 0;
        instr_ready_i = (hold > 0) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        in_seq  = 1'b1;
        for (int t = 0; t < 600 && in_seq; t++) begin
            if (t == 0 || t == 1) check("latency_not_yet", 32'(instr_valid_o), 32'd0);
            if (t == 2) check("latency_first_word", 32'(instr_valid_o), 32'd1);
            if (hold > 0 && t == hold) begin
                check("hold_req_count", 32'(req_seen), 32'((exp_reqs < DEPTH) ? exp_reqs : DEPTH));
                check("hold_req_low", 32'(rom_req_o), 32'd0);
                check("hold_valid", 32'(instr_valid_o), 32'd1);
            end
            start_i = restart && (t == 3);
            instr_ready_i = (t < hold) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
            tick();
        end
        start_i = 1'b0;
        instr_ready_i = 1'b0;
        if (in_seq) begin
            check("seq_timeout", 32'd0, 32'd1);
            do_reset();
            in_seq = 1'b0;
        end
        tick();
        tick();
        check("req_count", 32'(req_seen), 32'(exp_reqs));
        check("pop_count", 32'(pop_seen), 32'(exp_reqs));
        check("done_count", 32'(done_seen), 32'd1);
        check("idle_req", 32'(rom_req_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < MAXW; i++) rom[i] = '0;

        // Reset values
        tick();
        tick();
        check("rst_req", 32'(rom_req_o), 32'd0);
        check("rst_addr", rom_addr_o, 32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        tick();
        mon_en = 1'b1;

        // Basic dret-terminated routine, consumer always ready
        load_basic();
        run_seq(100, 0, 1'b0);
        // Backpressure: consumer stalled for the first cycles
        run_seq(100, 10, 1'b0);

        // No dret: the limit ends the sequence, with and without stalls
        for (int i = 0; i < MAXW; i++) rom[i] = 32'h0000_0013;
        run_seq(100, 0, 1'b0);
        run_seq(60, 6, 1'b0);
        // start_i while busy is ignored; requests keep counting upward
        run_seq(50, 0, 1'b1);

        // Flush in the cycle the second word is captured
        mon_en = 1'b0;
        load_basic();
        instr_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("flush_pre_valid", 32'(instr_valid_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_valid", 32'(instr_valid_o), 32'd0);
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_done", 32'(done_o), 32'd0);
        check("flush_req", 32'(rom_req_o), 32'd0);
        tick();
        tick();
        check("flush_dropped", 32'(instr_valid_o), 32'd0);
        check("flush_idle_busy", 32'(busy_o), 32'd0);
        mon_en = 1'b1;
        run_seq(100, 0, 1'b0);

        // start_i together with flush_i in IDLE
        mon_en = 1'b0;
        start_i = 1'b1;
        flush_i = 1'b1;
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        check("startflush_busy", 32'(busy_o), 32'd0);
        check("startflush_req", 32'(rom_req_o), 32'd0);
        tick();
        check("startflush_busy2", 32'(busy_o), 32'd0);
        check("startflush_valid", 32'(instr_valid_o), 32'd0);

        // Reset in FETCH with a response pending
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_req", 32'(rom_req_o), 32'd0);
        check("midrst_addr", rom_addr_o, 32'h0);
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        tick();
        tick();
        check("midrst_not_pushed", 32'(instr_valid_o), 32'd0);
        mon_en = 1'b1;

        // Randomized ROM contents and consumer behaviour
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < MAXW; i++) begin
                int r;
                r = int'($urandom_range(9));
                rom[i] = (r == 0) ? STOP : (r == 1) ? 32'h0 : $urandom;
            end
            run_seq(int'($urandom_range(30, 100)),
                    ($urandom_range(1) == 1) ? int'($urandom_range(4, 12)) : 0,
                    1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
